// File: rtl/tone_direction_decoder.sv
// -----------------------------------------------------------------------------
// tone_direction_decoder
//
// Purpose:
//   Answers the drive controller's junction tone request. While
//   enableToneDetection is high the rising edges of the microphone comparator
//   output are counted over fixed windows. Each window count is classified
//   into a direction code, and once the same in-band code has been seen for
//   CONFIRM consecutive windows it is latched onto toneDir. The code is held
//   until the request is withdrawn.
//
// Ports:
//   clk                  in   1      system clock
//   rst                  in   1      asynchronous, active-high reset
//   toneIn               in   1      comparator square wave, asynchronous to clk
//   enableToneDetection  in   1      request level from the drive controller
//   toneDir              out  3      HOLD=0 FORWARD=1 LEFT=2 RIGHT=3 REVERSE=4 STOP=5
//   lastCount            out  CNT_W  edge count of the most recently completed window
//   decState             out  2      IDLE=0 MEASURE=1 DECIDED=2
// -----------------------------------------------------------------------------
module tone_direction_decoder #(
  parameter int WINDOW_CYCLES = 5_000_000,
  parameter int CNT_W         = 16,
  parameter int BAND_FWD      = 100,
  parameter int BAND_LEFT     = 200,
  parameter int BAND_RIGHT    = 300,
  parameter int BAND_REV      = 400,
  parameter int BAND_STOP     = 500,
  parameter int TOL           = 20,
  parameter int CONFIRM       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toneIn,
  input  logic             enableToneDetection,
  output logic [2:0]       toneDir,
  output logic [CNT_W-1:0] lastCount,
  output logic [1:0]       decState
);

  // ---------------------------------------------------------------------------
  // Types and derived constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DECIDED = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    TD_HOLD    = 3'd0,
    TD_FORWARD = 3'd1,
    TD_LEFT    = 3'd2,
    TD_RIGHT   = 3'd3,
    TD_REVERSE = 3'd4,
    TD_STOP    = 3'd5
  } dir_t;

  localparam int WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int STREAK_W = (CONFIRM > 0) ? $clog2(CONFIRM + 1) : 1;

  localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [STREAK_W-1:0] STREAK_DONE = STREAK_W'(CONFIRM);

  // ---------------------------------------------------------------------------
  // Classification: bands are tested in ascending order so that, should two
  // bands ever be configured to touch, the lower direction wins.
  // ---------------------------------------------------------------------------
  function automatic logic in_band(input int count, input int centre);
    return (count >= centre - TOL) && (count <= centre + TOL);
  endfunction

  function automatic dir_t classify(input logic [CNT_W-1:0] count);
    int c;
    c = int'(count);
    if      (in_band(c, BAND_FWD))   return TD_FORWARD;
    else if (in_band(c, BAND_LEFT))  return TD_LEFT;
    else if (in_band(c, BAND_RIGHT)) return TD_RIGHT;
    else if (in_band(c, BAND_REV))   return TD_REVERSE;
    else if (in_band(c, BAND_STOP))  return TD_STOP;
    else                             return TD_HOLD;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync3;       // previous synchronized level (edge register)
  state_t              r_state;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;
  dir_t                r_cand;
  logic [STREAK_W-1:0] r_streak;
  dir_t                r_tone_dir;
  logic [CNT_W-1:0]    r_last_count;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic                w_rise;
  logic                w_window_done;
  logic [CNT_W-1:0]    w_count_final;
  dir_t                w_code;
  logic [STREAK_W-1:0] w_streak_new;
  dir_t                w_cand_new;

  state_t              w_state_nxt;
  logic [WIN_W-1:0]    w_win_nxt;
  logic [CNT_W-1:0]    w_edge_nxt;
  dir_t                w_cand_nxt;
  logic [STREAK_W-1:0] w_streak_nxt;
  dir_t                w_dir_nxt;
  logic [CNT_W-1:0]    w_last_nxt;

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer followed by a registered edge detect.
  // A rising toneIn is first seen by r_sync1, reaches r_sync2 one edge later,
  // and the count register captures it on the third edge.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= toneIn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise        = r_sync2 & ~r_sync3;
  assign w_window_done = (r_win_cnt == WIN_LAST);

  // Count including an edge arriving on this very cycle; sticks at CNT_MAX.
  assign w_count_final = (w_rise && (r_edge_cnt != CNT_MAX))
                         ? r_edge_cnt + CNT_W'(1)
                         : r_edge_cnt;

  assign w_code = classify(w_count_final);

  // Candidate/streak update applied at the end of each window.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    w_cand_new   = r_cand;
    w_streak_new = r_streak;
    if (w_code == TD_HOLD) begin
      w_cand_new   = TD_HOLD;
      w_streak_new = '0;
    end else if (w_code == r_cand) begin
      w_streak_new = r_streak + STREAK_W'(1);
    end else begin
      w_cand_new   = w_code;
      w_streak_new = STREAK_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_win_nxt    = r_win_cnt;
    w_edge_nxt   = r_edge_cnt;
    w_cand_nxt   = r_cand;
    w_streak_nxt = r_streak;
    w_dir_nxt    = r_tone_dir;
    w_last_nxt   = r_last_count;

    if (!enableToneDetection) begin
      // Withdrawal wins over anything else happening this cycle, including a
      // window that would have confirmed a decision.
      w_state_nxt = ST_IDLE;
      w_dir_nxt   = TD_HOLD;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Fresh measurement: nothing from a previous request carries over.
          w_state_nxt  = ST_MEASURE;
          w_win_nxt    = '0;
          w_edge_nxt   = '0;
          w_cand_nxt   = TD_HOLD;
          w_streak_nxt = '0;
          w_dir_nxt    = TD_HOLD;
        end

        ST_MEASURE: begin
          if (w_window_done) begin
            w_last_nxt   = w_count_final;
            w_cand_nxt   = w_cand_new;
            w_streak_nxt = w_streak_new;
            // The next window starts on the following cycle with no gap.
            w_win_nxt    = '0;
            w_edge_nxt   = '0;
            if (w_streak_new == STREAK_DONE) begin
              w_state_nxt = ST_DECIDED;
              w_dir_nxt   = w_code;
            end
          end else begin
            w_win_nxt  = r_win_cnt + WIN_W'(1);
            w_edge_nxt = w_count_final;
          end
        end

        ST_DECIDED: begin
          // Decision held; counters frozen until the request is withdrawn.
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_dir_nxt   = TD_HOLD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_cand       <= TD_HOLD;
      r_streak     <= '0;
      r_tone_dir   <= TD_HOLD;
      r_last_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_win_cnt    <= w_win_nxt;
      r_edge_cnt   <= w_edge_nxt;
      r_cand       <= w_cand_nxt;
      r_streak     <= w_streak_nxt;
      r_tone_dir   <= w_dir_nxt;
      r_last_count <= w_last_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign toneDir   = r_tone_dir;
  assign lastCount = r_last_count;
  assign decState  = r_state;

endmodule

// File: doc/tone_direction_decoder.md
# tone_direction_decoder

Answers the drive controller's junction tone request. While `enableToneDetection` is high, it measures the frequency of the microphone comparator output over fixed windows and classifies it into one of five direction codes. After a code has been confirmed it presents that code on `toneDir`, and holds it until the request is withdrawn. It sits between the audio front end and the drive controller's junction state machine.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 5_000_000: measurement window length in clk cycles (100 ms at 50 MHz).
- `CNT_W`, default 16: edge-counter width; the counter saturates at 2^CNT_W-1.
- `BAND_FWD`, `BAND_LEFT`, `BAND_RIGHT`, `BAND_REV`, `BAND_STOP`, defaults 100/200/300/400/500: nominal rising-edge counts per window (1–5 kHz).
- `TOL`, default 20: band half-width in edges. Bands must not overlap.
- `CONFIRM`, default 2: number of consecutive identical in-band windows required for a decision.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `toneIn`  in  1  comparator square wave, asynchronous to clk.
- `enableToneDetection`  in  1  request level from the drive controller.
- `toneDir`  out  3  direction code: TD_HOLD=0, TD_FORWARD=1, TD_LEFT=2, TD_RIGHT=3, TD_REVERSE=4, TD_STOP=5.
- `lastCount`  out  CNT_W  edge count of the most recently completed window (debug).
- `decState`  out  2  state: IDLE=0, MEASURE=1, DECIDED=2.

## Operation
Reset values:
- `toneDir`=TD_HOLD, `lastCount`=0, `decState`=IDLE.
- Synchronizer flops, edge register, window counter, edge counter, candidate and streak all 0.

Input path:
- `toneIn` passes through a 2-flop synchronizer, then a registered rising-edge detect.
- Edges are counted only in MEASURE.

IDLE:
- `toneDir`=TD_HOLD.
- On `enableToneDetection`=1: go to MEASURE and clear the window counter, edge counter, candidate (=TD_HOLD) and streak (=0).

MEASURE:
- The window counter runs 0..WINDOW_CYCLES-1.
- On the last cycle of a window, classify `count_final`, the edge count including any edge detected in that cycle. Check bands in ascending order; `count_final` in [BAND_x-TOL, BAND_x+TOL] gives code x, otherwise TD_HOLD.
- `lastCount` is updated with `count_final`.
- Code TD_HOLD: streak=0, candidate=TD_HOLD.
- Code equal to the candidate: streak+1.
- Any other code: candidate=code, streak=1.
- If the new streak equals CONFIRM: go to DECIDED and load `toneDir` with the code, on that same edge.
- Otherwise the next window starts immediately: both counters reset to 0 and no cycle is skipped.

DECIDED:
- `toneDir` holds the decided code.
- Counting stops.

Any state:
- `enableToneDetection`=0 gives IDLE and `toneDir`=TD_HOLD on the next edge.
- This takes priority over a window completing in the same cycle.

Other rules:
- The edge counter saturates and does not wrap.
- `toneIn` activity outside MEASURE has no effect.
- Re-asserting enable after a decision starts a fresh measurement; no stale candidate is carried over.

## Timing
- Synchronizer plus edge detect: an edge is counted 3 clk edges after `toneIn` rises.
- Minimum decision latency from the enable rise: 1 + CONFIRM×WINDOW_CYCLES clk edges to valid `toneDir`.
- Enable drop to TD_HOLD: 1 cycle.
- `toneDir` only changes between TD_HOLD and the decided code; it never moves directly from one direction to another while enable stays high.
- Asynchronous reset mid-window: all state clears immediately. After reset is released, measurement restarts only once enable is sampled high.

## Test plan
Bench parameters: WINDOW_CYCLES=1000, BANDs 10/20/30/40/50, TOL=2, CONFIRM=2.
- Enable held, `toneIn` period 100 cycles (10 edges/window) -> `toneDir`=1 on edge 2001 after the enable sample; `lastCount`=10; `decState`=2.
- Period 50 cycles, then 34 cycles (20, then ~29 edges) -> after window 1 candidate=LEFT; after window 2 candidate=RIGHT with streak=1; `toneDir`=3 after window 3.
- Out-of-band tone of 15 edges/window for 10 windows -> `toneDir` stays 0; `decState` stays 1; `lastCount`=15.
- Decision made (`toneDir`=5), then enable dropped -> `toneDir`=0 and `decState`=0 next cycle. Re-enable with a 40-edge tone -> 4 after 2 new windows.
- Async `rst` pulse at window cycle 600 of window 2 -> outputs reset immediately. After release with enable high, the first decision comes 2 full windows later.
- Enable drop on the exact window-final cycle of a confirming window -> `toneDir` remains 0 and state goes to IDLE.
- Edge-counter saturation: CNT_W=4 with 20 edges/window -> `lastCount`=15; no wrap.
